float_to_fixed_seq: RTL and testbench

Sequential IEEE-754 binary32 to signed fixed-point converter. It is the float-to-fixed stage feeding the `fixresult` leg of the conversion top, alongside the fixed-to-float path. It accepts one operand per handshake and shifts the mantissa one bit per cycle. It then saturates, negates and holds the 32-bit two's-complement result until it is consumed.

---
 rtl/fixfloat_pkg.sv | 19 +
 rtl/fix_saturate.sv | 24 ++
 rtl/float_to_fixed_seq.sv | 173 +++++++++++++++++
 tb/tb_float_to_fixed_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixfloat_pkg.sv
// Shared constants and FSM state type for the float/fixed conversion paths.
// Used by float_to_fixed_seq, fix_saturate and the fixed-to-float direction.
package fixfloat_pkg;

   localparam int EXP_BIAS = 127;
   localparam int MANT_W   = 23;
   localparam int EXP_W    = 8;

   localparam logic [31:0] FIX_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] FIX_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FIN,
      DONE
   } cvt_state_t;

endpackage

// File: rtl/fix_saturate.sv
// Clamp a 33-bit magnitude into 32-bit two's complement and apply the sign.
// Ports: s (sign), mag (magnitude) -> result, overflow (clamped).
module fix_saturate
   import fixfloat_pkg::*;
(
   input  logic        s,
   input  logic [32:0] mag,
   output logic [31:0] result,
   output logic        overflow
);

   always_comb begin
      overflow = 1'b0;
      result   = s ? (~mag[31:0] + 32'd1) : mag[31:0];
      if (!s && (mag > {1'b0, FIX_MAX})) begin
         result   = FIX_MAX;
         overflow = 1'b1;
      end else if (s && (mag > {1'b0, FIX_MIN})) begin
         result   = FIX_MIN;
         overflow = 1'b1;
      end
   end

endmodule

// File: rtl/float_to_fixed_seq.sv
// Sequential binary32 -> 32-bit signed fixed-point converter, 1 shift/cycle.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, targetnumber,
//   fixpointpos, out_valid/out_ready, result, overflow, invalid.
// Option: define FLOAT2FIX_ROUND_EN for round-half-away-from-zero.
module float_to_fixed_seq
   import fixfloat_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] targetnumber,
   input  logic [4:0]  fixpointpos,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        invalid
);

`ifdef FLOAT2FIX_ROUND_EN
   localparam logic [9:0] TINY_LIM = 10'd25;
`else
   localparam logic [9:0] TINY_LIM = 10'd24;
`endif
   // Any value above FIX_MIN forces saturation for both signs.
   localparam logic [32:0] SAT_MAG = 33'h1_0000_0000;

   cvt_state_t state, nxt;

   logic        s_q;
   logic        left_q;
   logic        inv_q;
   logic [32:0] mag_q;
   logic [4:0]  cnt_q;
`ifdef FLOAT2FIX_ROUND_EN
   logic        g_q;
`endif

   logic [EXP_W-1:0]  e;
   logic [MANT_W-1:0] fr;
   logic signed [9:0] sh;
   logic [9:0]        nsh;
   logic special, is_zero, is_nan, is_inf;
   logic big, tiny;
   logic kill, sat, go_l, go_r;
   logic [32:0] acc_mag;
   logic [4:0]  acc_n;
   logic [32:0] fin_mag;
   logic [31:0] sat_res;
   logic        sat_ov;

   assign e  = targetnumber[30:23];
   assign fr = targetnumber[MANT_W-1:0];
   // 150 = bias + mantissa width: M is an integer scaled by 2^(exp-150).
   assign sh = $signed({2'b00, e})
             + $signed({5'b00000, fixpointpos})
             - 10'sd150;
   assign nsh = $unsigned(-sh);

   assign is_zero = (e == '0);
   assign is_nan  = (e == '1) & (|fr);
   assign is_inf  = (e == '1) & ~(|fr);
   assign special = (e == '0) | (e == '1);
   assign big     = ~sh[9] & (sh >= 10'sd9);
   assign tiny    = sh[9] & (nsh >= TINY_LIM);

   // Mutually exclusive operand classes.
   assign kill = is_zero | is_nan | (~special & tiny);
   assign sat  = is_inf | (~special & big);
   assign go_l = ~special & ~sh[9] & ~big;
   assign go_r = ~special & sh[9] & ~tiny;

   always_comb begin
      acc_mag = '0;
      acc_n   = '0;
      unique case (1'b1)
         kill: acc_mag = '0;
         sat:  acc_mag = SAT_MAG;
         go_l: begin
            acc_mag = {9'd0, 1'b1, fr};
            acc_n   = sh[4:0];
         end
         go_r: begin
            acc_mag = {9'd0, 1'b1, fr};
            acc_n   = nsh[4:0];
         end
         default: ;
      endcase
   end

`ifdef FLOAT2FIX_ROUND_EN
   assign fin_mag = mag_q + {32'd0, g_q};
`else
   assign fin_mag = mag_q;
`endif

   fix_saturate u_sat (
      .s        (s_q),
      .mag      (fin_mag),
      .result   (sat_res),
      .overflow (sat_ov)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (in_valid)
                   nxt = (acc_n == '0) ? FIN : SHIFT;
         SHIFT: if (cnt_q == 5'd1) nxt = FIN;
         FIN:   nxt = DONE;
         DONE:  if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q      <= 1'b0;
         left_q   <= 1'b0;
         inv_q    <= 1'b0;
         mag_q    <= '0;
         cnt_q    <= '0;
`ifdef FLOAT2FIX_ROUND_EN
         g_q      <= 1'b0;
`endif
         result   <= '0;
         overflow <= 1'b0;
         invalid  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               s_q    <= targetnumber[31];
               left_q <= go_l;
               inv_q  <= is_nan;
               mag_q  <= acc_mag;
               cnt_q  <= acc_n;
`ifdef FLOAT2FIX_ROUND_EN
               g_q    <= 1'b0;
`endif
            end
            SHIFT: begin
               cnt_q <= cnt_q - 5'd1;
               if (left_q) begin
                  mag_q <= {mag_q[31:0], 1'b0};
               end else begin
                  mag_q <= {1'b0, mag_q[32:1]};
`ifdef FLOAT2FIX_ROUND_EN
                  g_q   <= mag_q[0];
`endif
               end
            end
            FIN: begin
               result   <= sat_res;
               overflow <= sat_ov;
               invalid  <= inv_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_fixed_seq.sv
// Bench for float_to_fixed_seq: directed vectors plus random operands
// checked against an arithmetic reference model.
module tb_float_to_fixed_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] targetnumber;
   logic [4:0]  fixpointpos;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        invalid;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef FLOAT2FIX_ROUND_EN
   localparam int MAXR = 24;
   localparam bit RND  = 1'b1;
`else
   localparam int MAXR = 23;
   localparam bit RND  = 1'b0;
`endif

   float_to_fixed_seq dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .targetnumber (targetnumber),
      .fixpointpos  (fixpointpos),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .overflow     (overflow),
      .invalid      (invalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Value = M * 2^(exp-150+p), then round/truncate and clamp as a
   // signed integer.
   function automatic void ref_cvt(input logic [31:0] f,
                                   input logic [4:0] p,
                                   output logic [31:0] r,
                                   output logic ov,
                                   output logic inv,
                                   output int lat);
      int e, sh, d;
      longint m, mag, v;
      bit g;
      e   = int'(f[30:23]);
      sh  = e - 150 + int'(p);
      m   = longint'({1'b1, f[22:0]});
      g   = 1'b0;
      inv = 1'b0;
      lat = 2;
      mag = 0;
      if (e == 0) begin
         mag = 0;
      end else if (e == 255) begin
         inv = (f[22:0] != 0);
         mag = inv ? 0 : (longint'(1) << 40);
      end else if (sh >= 9) begin
         mag = longint'(1) << 40;
      end else if (sh >= 0) begin
         mag = m << sh;
         lat = sh + 2;
      end else begin
         d = -sh;
         if (d <= MAXR) begin
            mag = m >> d;
            g   = m[d-1];
            lat = d + 2;
         end
      end
      if (RND) mag = mag + longint'(g);
      v = f[31] ? -mag : mag;
      ov = 1'b0;
      if (v > longint'(32'h7FFF_FFFF)) begin
         r  = 32'h7FFF_FFFF;
         ov = 1'b1;
      end else if (v < -longint'(64'd2147483648)) begin
         r  = 32'h8000_0000;
         ov = 1'b1;
      end else begin
         r = v[31:0];
      end
   endfunction

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic recover();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic xfer(input logic [31:0] f,
                       input logic [4:0] p,
                       input int hold);
      logic [31:0] r;
      logic        ov, inv;
      int          lat, lat_x;
      ref_cvt(f, p, r, ov, inv, lat_x);
      chk("pre_rdy", in_ready, 1'b1);
      in_valid     = 1'b1;
      targetnumber = f;
      fixpointpos  = p;
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      targetnumber = $urandom;
      fixpointpos  = 5'($urandom);
      wait_out(lat);
      chk("lat", lat, lat_x);
      if (!out_valid) begin
         recover();
         return;
      end
      chk("res", result, r);
      chk("ovf", overflow, ov);
      chk("inv", invalid, inv);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_vld", out_valid, 1'b1);
         chk("hold_rdy", in_ready, 1'b0);
         chk("hold_res", result, r);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("post_vld", out_valid, 1'b0);
   endtask

   logic [31:0] dv_f [10] = '{
      32'h3FC0_0000, 32'hC020_0000, 32'h4049_0FDB, 32'h4F00_0000,
      32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h3F40_0000,
      32'h3F80_0000, 32'h0000_0001
   };
   logic [4:0] dv_p [10] = '{
      5'd0, 5'd0, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd5
   };

   initial begin
      logic [31:0] f, r2;
      logic [7:0]  e8;
      logic        ov2, inv2, seen;
      int          lat, lat2;

      rst          = 1'b1;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      targetnumber = '0;
      fixpointpos  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_rdy", in_ready, 1'b1);
      chk("rst_vld", out_valid, 1'b0);
      chk("rst_res", result, 32'h0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_inv", invalid, 1'b0);

      for (int i = 0; i < 10; i++)
         xfer(dv_f[i], dv_p[i], (i == 2) ? 5 : 0);

      // Same-cycle consume plus new operand: accepted one edge later.
      xfer(32'h4049_0FDB, 5'd16, 0);
      in_valid     = 1'b1;
      targetnumber = 32'hC020_0000;
      fixpointpos  = 5'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      wait_out(lat);
      if (out_valid) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         chk("sc_idle", in_ready, 1'b1);
         chk("sc_vld", out_valid, 1'b0);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("sc_acc", in_ready, 1'b0);
         wait_out(lat);
         ref_cvt(32'hC020_0000, 5'd0, r2, ov2, inv2, lat2);
         chk("sc_lat", lat, lat2);
         chk("sc_res", result, r2);
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end else begin
         chk("sc_first", out_valid, 1'b1);
         recover();
      end
      in_valid = 1'b0;

      // Reset in the middle of a long shift.
      xfer(32'hCF00_0000, 5'd0, 0);
      in_valid     = 1'b1;
      targetnumber = 32'h3FC0_0000;
      fixpointpos  = 5'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst_vld", out_valid, 1'b0);
      chk("mrst_rdy", in_ready, 1'b1);
      chk("mrst_res", result, 32'h0);
      chk("mrst_ovf", overflow, 1'b0);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         seen |= out_valid;
      end
      chk("mrst_drop", seen, 1'b0);

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 9))
            0:       e8 = 8'd0;
            1:       e8 = 8'd255;
            default: e8 = 8'($urandom_range(100, 170));
         endcase
         f = {1'($urandom), e8, 23'($urandom)};
         if ($urandom_range(0, 3) == 0) f[22:0] = '0;
         xfer(f, 5'($urandom), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
